// File: rtl/mux2_arbiter_2bit_pkg.sv
// mux2_arbiter_2bit_pkg: channel and output-stage state encodings shared by the arbiter.
package mux2_arbiter_2bit_pkg;
    localparam logic CH1 = 1'b0;
    localparam logic CH2 = 1'b1;
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
endpackage

// File: rtl/Mux_2_input_2bit.sv
// Mux_2_input_2bit: 2-input, 2-bit data selector (S=0 picks Input_1).
module Mux_2_input_2bit (
    input  logic [1:0] Input_1,
    input  logic [1:0] Input_2,
    input  logic       S,
    output logic [1:0] Out
);
    assign Out = S ? Input_2 : Input_1;
endmodule

// File: rtl/mux2_arbiter_2bit.sv
// mux2_arbiter_2bit: two-channel valid/ready arbiter feeding a single registered 2-bit output slot.
module mux2_arbiter_2bit
    import mux2_arbiter_2bit_pkg::*;
#(
    parameter int RR_EN    = 1,
    parameter int START_CH = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] in1_data,
    input  logic       in1_valid,
    output logic       in1_ready,
    input  logic [1:0] in2_data,
    input  logic       in2_valid,
    output logic       in2_ready,
    output logic [1:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sel,
    output logic       busy
);
    logic [0:0] state;
    logic       last_grant;
    logic       sel_q;
    logic       grant;
    logic       load;
    logic [1:0] mux_out;

    // Readies are gated by rst_n so they drop the moment reset is asserted.
    assign load      = rst_n && (in1_valid || in2_valid) && (state == EMPTY || out_ready);
    assign grant     = (in1_valid && in2_valid) ? ((RR_EN != 0) ? ~last_grant : CH1)
                                                : (in2_valid ? CH2 : CH1);
    assign sel       = load ? grant : sel_q;
    assign in1_ready = load && grant == CH1;
    assign in2_ready = load && grant == CH2;
    assign out_valid = state == FULL;
    assign busy      = out_valid && !out_ready;

    Mux_2_input_2bit u_mux (
        .Input_1 (in1_data),
        .Input_2 (in2_data),
        .S       (sel),
        .Out     (mux_out)
    );

    // last_grant starts on the opposite channel so START_CH wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= (START_CH != 0) ? CH1 : CH2;
            sel_q      <= (START_CH != 0) ? CH2 : CH1;
            out_data   <= 2'b00;
        end else if (load) begin
            state      <= FULL;
            last_grant <= grant;
            sel_q      <= grant;
            out_data   <= mux_out;
        end else if (out_ready) begin
            state      <= EMPTY;
        end
    end
endmodule

// File: tb/tb_mux2_arbiter_2bit.sv
// tb_mux2_arbiter_2bit: directed and random checks of the round-robin and fixed-priority arbiter.
module tb_mux2_arbiter_2bit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in1_data, in2_data;
    logic       in1_valid, in2_valid, out_ready;
    logic       in1_ready, in2_ready, out_valid, sel, busy;
    logic [1:0] out_data;
    logic       fp_in1_ready, fp_in2_ready, fp_out_valid, fp_sel, fp_busy;
    logic [1:0] fp_out_data;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] q[$];
    logic       mfull, mlast, eld, eg;

    always #5 clk = ~clk;

    mux2_arbiter_2bit #(.RR_EN(1), .START_CH(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .in2_data(in2_data), .in2_valid(in2_valid), .in2_ready(in2_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel(sel), .busy(busy)
    );

    mux2_arbiter_2bit #(.RR_EN(0), .START_CH(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(fp_in1_ready),
        .in2_data(in2_data), .in2_valid(in2_valid), .in2_ready(fp_in2_ready),
        .out_data(fp_out_data), .out_valid(fp_out_valid), .out_ready(out_ready),
        .sel(fp_sel), .busy(fp_busy)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1 rst_n  = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in1_valid = 1'b1; in1_data = 2'b10;
        in2_valid = 1'b0; in2_data = 2'b00; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_in2_ready", in2_ready, 0);
        chk("rst_sel", sel, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("first_in1_ready", in1_ready, 1);
        chk("first_in2_ready", in2_ready, 0);
        @(posedge clk); #1;
        chk("first_out_valid", out_valid, 1);
        chk("first_out_data", out_data, 2'b10);
        chk("first_sel", sel, 0);

        do_reset();
        in1_data = 2'b01; in2_data = 2'b11;
        in1_valid = 1'b1; in2_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_sel", sel, i[0]);
            chk("rr_in1_ready", in1_ready, !i[0]);
            if (i < 3) chk("fp_in2_ready", fp_in2_ready, 0);
            @(posedge clk); #1;
            chk("rr_out_data", out_data, i[0] ? 2'b11 : 2'b01);
            if (i < 3) chk("fp_out_data", fp_out_data, 2'b01);
        end

        in1_valid = 1'b0; in2_data = 2'b10; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_busy", busy, 1);
            chk("stall_in2_ready", in2_ready, 0);
            chk("stall_out_data", out_data, 2'b11);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in2_ready", in2_ready, 1);
        @(posedge clk); #1;
        chk("unstall_out_data", out_data, 2'b10);
        chk("unstall_out_valid", out_valid, 1);

        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_out_data", out_data, 0);
        chk("async_sel", sel, 0);
        chk("async_in2_ready", in2_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        in1_valid = 1'b1; in2_valid = 1'b1; in1_data = 2'b01; in2_data = 2'b11;
        #1;
        chk("restart_in1_ready", in1_ready, 1);
        chk("restart_in2_ready", in2_ready, 0);
        @(posedge clk); #1;
        chk("restart_out_data", out_data, 2'b01);

        do_reset();
        mfull = 1'b0; mlast = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            in1_valid = 1'($urandom_range(0, 1));
            in2_valid = 1'($urandom_range(0, 1));
            in1_data  = 2'($urandom_range(0, 3));
            in2_data  = 2'($urandom_range(0, 3));
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            eld = (!mfull || out_ready) && (in1_valid || in2_valid);
            eg  = (in1_valid && in2_valid) ? ~mlast : in2_valid;
            chk("rnd_out_valid", out_valid, mfull);
            chk("rnd_in1_ready", in1_ready, eld && !eg);
            chk("rnd_in2_ready", in2_ready, eld && eg);
            chk("rnd_ready_wo_valid", (in1_ready && !in1_valid) || (in2_ready && !in2_valid), 0);
            if (mfull && out_ready) begin
                if (q.size() == 0) chk("rnd_extra_item", 1, 0);
                else chk("rnd_out_data", out_data, q.pop_front());
            end
            if (eld) begin
                q.push_back(eg ? in2_data : in1_data);
                mlast = eg;
            end
            mfull = eld ? 1'b1 : (out_ready ? 1'b0 : mfull);
            @(posedge clk); #1;
        end
        chk("rnd_pending", 8'(q.size()), {7'd0, mfull});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
